// File: rtl/rggen_rtl_pkg.sv
// Shared RgGen bus encodings plus the bus-bridge state type reused by all host bridges.
package rggen_rtl_pkg;
    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        RGGEN_BRIDGE_IDLE    = 2'b00,
        RGGEN_BRIDGE_ACCESS  = 2'b01,
        RGGEN_BRIDGE_RESPOND = 2'b10
    } rggen_bridge_state;
endpackage

// File: rtl/rggen_register_if.sv
// Request/response channel between a bus bridge and one register instance.
interface rggen_register_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                     valid;
    rggen_access              access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     active;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport host (
        output valid, access, address, write_data, strobe,
        input  active, ready, status, read_data
    );

    modport register (
        input  valid, access, address, write_data, strobe,
        output active, ready, status, read_data
    );
endinterface

// File: rtl/rggen_or_reducer.sv
// Bitwise OR of N equally sized words.
module rggen_or_reducer #(
    parameter int WIDTH = 2,
    parameter int N     = 2
)(
    input  logic [N-1:0][WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]        o_result
);
    always_comb begin
        o_result = '0;
        for (int i = 0; i < N; i++) begin
            o_result = o_result | i_data[i];
        end
    end
endmodule

// File: rtl/rggen_native_bus_bridge.sv
// Valid/ready host bus to rggen_register_if bridge: one outstanding transaction,
// with decode-error and timeout responses generated locally.
module rggen_native_bus_bridge #(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int REGISTERS      = 1,
    parameter bit ERROR_STATUS   = 1'b1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int COUNTER_WIDTH  = 8
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_write,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address,
    input  logic [BUS_WIDTH-1:0]     i_req_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_req_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_status,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    rggen_register_if.host           register_if[REGISTERS]
);
    import rggen_rtl_pkg::*;

    localparam int STROBE_WIDTH = BUS_WIDTH / 8;
    localparam int LSB_WIDTH    = $clog2(STROBE_WIDTH);
    localparam int MERGE_WIDTH  = BUS_WIDTH + 2;
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
        ~ADDRESS_WIDTH'((2 ** LSB_WIDTH) - 1);
    localparam bit TIMEOUT_EN = TIMEOUT_CYCLES > 0;
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
        COUNTER_WIDTH'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam rggen_status DECODE_STATUS = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

    rggen_bridge_state          state;
    logic                       access_valid;
    logic                       access_write;
    logic [ADDRESS_WIDTH-1:0]   access_address;
    logic [BUS_WIDTH-1:0]       access_write_data;
    logic [STROBE_WIDTH-1:0]    access_strobe;
    logic [COUNTER_WIDTH-1:0]   wait_count;

    logic [REGISTERS-1:0]                  active;
    logic [REGISTERS-1:0]                  ready;
    logic [REGISTERS-1:0][MERGE_WIDTH-1:0] rsp_data;
    logic [MERGE_WIDTH-1:0]                merged;
    rggen_status                           merged_status;

    logic                       complete;
    rggen_status                complete_status;
    logic [BUS_WIDTH-1:0]       complete_data;

    for (genvar g = 0; g < REGISTERS; g++) begin : g_register
        assign register_if[g].valid      = access_valid;
        assign register_if[g].access     = access_write ? RGGEN_WRITE : RGGEN_READ;
        assign register_if[g].address    = access_address;
        assign register_if[g].write_data = access_write_data;
        assign register_if[g].strobe     = access_strobe;
        assign active[g]                 = register_if[g].active;
        assign ready[g]                  = register_if[g].ready;
        // Inactive registers are masked so stray read data cannot leak into the merge.
        assign rsp_data[g] = register_if[g].active
                           ? {register_if[g].status, register_if[g].read_data} : '0;
    end

    rggen_or_reducer #(
        .WIDTH (MERGE_WIDTH),
        .N     (REGISTERS)
    ) u_response_merge (
        .i_data   (rsp_data),
        .o_result (merged)
    );

    assign merged_status = rggen_status'(merged[MERGE_WIDTH-1-:2]);
    assign o_req_ready   = state == RGGEN_BRIDGE_IDLE;

    // Completion priority: register ready, then decode miss, then timeout.
    always_comb begin
        complete        = 1'b1;
        complete_status = RGGEN_SLAVE_ERROR;
        complete_data   = '0;
        if (|(active & ready)) begin
            complete_status = merged_status;
            complete_data   = access_write ? '0 : merged[BUS_WIDTH-1:0];
        end else if (!(|active)) begin
            complete_status = DECODE_STATUS;
        end else begin
            complete = TIMEOUT_EN && (wait_count == TIMEOUT_LAST);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= RGGEN_BRIDGE_IDLE;
            access_valid      <= 1'b0;
            access_write      <= 1'b0;
            access_address    <= '0;
            access_write_data <= '0;
            access_strobe     <= '0;
            wait_count        <= '0;
            o_rsp_valid       <= 1'b0;
            o_rsp_status      <= RGGEN_OKAY;
            o_rsp_read_data   <= '0;
        end else begin
            case (state)
                RGGEN_BRIDGE_IDLE: begin
                    if (i_req_valid) begin
                        state             <= RGGEN_BRIDGE_ACCESS;
                        access_valid      <= 1'b1;
                        access_write      <= i_req_write;
                        access_address    <= i_req_address & ALIGN_MASK;
                        access_write_data <= i_req_write ? i_req_write_data : '0;
                        access_strobe     <= i_req_write ? i_req_strobe : '1;
                        wait_count        <= '0;
                    end
                end
                RGGEN_BRIDGE_ACCESS: begin
                    if (complete) begin
                        state           <= RGGEN_BRIDGE_RESPOND;
                        access_valid    <= 1'b0;
                        o_rsp_valid     <= 1'b1;
                        o_rsp_status    <= complete_status;
                        o_rsp_read_data <= complete_data;
                    end else begin
                        wait_count <= wait_count + COUNTER_WIDTH'(1);
                    end
                end
                RGGEN_BRIDGE_RESPOND: begin
                    if (i_rsp_ready) begin
                        state       <= RGGEN_BRIDGE_IDLE;
                        o_rsp_valid <= 1'b0;
                    end
                end
                default: state <= RGGEN_BRIDGE_IDLE;
            endcase
        end
    end

`ifdef RGGEN_ENABLE_SVA
    ast_onehot_active: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (state == RGGEN_BRIDGE_ACCESS) |-> $onehot0(active)
    );
`endif

    ast_stable_response: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (o_rsp_valid && !i_rsp_ready) |=> $stable({o_rsp_valid, o_rsp_status, o_rsp_read_data})
    );
endmodule

// File: tb/tb_rggen_native_bus_bridge.sv
// Directed bench: two bridges (ERROR_STATUS=1/TIMEOUT=8 and ERROR_STATUS=0/TIMEOUT=4)
// each driving two modelled registers at 0x00 and 0x04.
module tb_rggen_native_bus_bridge;
    import rggen_rtl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid = 1'b0;
    logic        b_req_valid = 1'b0;
    logic        a_req_ready, b_req_ready;
    logic        req_write      = 1'b0;
    logic [7:0]  req_address    = 8'h00;
    logic [31:0] req_write_data = 32'h0;
    logic [3:0]  req_strobe     = 4'h0;
    logic        rsp_ready      = 1'b1;
    logic        a_rsp_valid, b_rsp_valid;
    logic [1:0]  a_rsp_status, b_rsp_status;
    logic [31:0] a_rsp_read_data, b_rsp_read_data;

    int total = 0;
    int bad   = 0;

    rggen_register_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) a_if [2] ();
    rggen_register_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) b_if [2] ();

    rggen_native_bus_bridge #(
        .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2),
        .ERROR_STATUS(1'b1), .TIMEOUT_CYCLES(8), .COUNTER_WIDTH(8)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
        .i_req_write(req_write), .i_req_address(req_address),
        .i_req_write_data(req_write_data), .i_req_strobe(req_strobe),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_status(a_rsp_status), .o_rsp_read_data(a_rsp_read_data),
        .register_if(a_if)
    );

    rggen_native_bus_bridge #(
        .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2),
        .ERROR_STATUS(1'b0), .TIMEOUT_CYCLES(4), .COUNTER_WIDTH(8)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
        .i_req_write(req_write), .i_req_address(req_address),
        .i_req_write_data(req_write_data), .i_req_strobe(req_strobe),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_status(b_rsp_status), .o_rsp_read_data(b_rsp_read_data),
        .register_if(b_if)
    );

    // Register model: decodes its own word address, becomes ready after wait_n cycles.
    for (genvar g = 0; g < 2; g++) begin : g_a
        logic [7:0]  wait_n = 8'd0;
        logic [31:0] rdata  = 32'h0;
        logic [1:0]  st     = 2'b00;
        logic [7:0]  cnt    = 8'd0;
        int          done_count = 0;
        logic [1:0]  last_access = 2'b00;
        logic [31:0] last_wdata  = 32'h0;
        logic [3:0]  last_strobe = 4'h0;
        logic        hit;
        assign hit = a_if[g].valid && (a_if[g].address == 8'(4 * g));
        assign a_if[g].active    = hit;
        assign a_if[g].ready     = hit && (cnt >= wait_n);
        assign a_if[g].read_data = hit ? rdata : 32'h0;
        assign a_if[g].status    = hit ? rggen_status'(st) : RGGEN_OKAY;
        always @(posedge clk) begin
            cnt <= hit ? cnt + 8'd1 : 8'd0;
            if (hit && (cnt >= wait_n)) begin
                done_count  <= done_count + 1;
                last_access <= a_if[g].access;
                last_wdata  <= a_if[g].write_data;
                last_strobe <= a_if[g].strobe;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_b
        logic [7:0]  wait_n = 8'd0;
        logic [31:0] rdata  = 32'h0;
        logic [7:0]  cnt    = 8'd0;
        logic        hit;
        assign hit = b_if[g].valid && (b_if[g].address == 8'(4 * g));
        assign b_if[g].active    = hit;
        assign b_if[g].ready     = hit && (cnt >= wait_n);
        assign b_if[g].read_data = hit ? rdata : 32'h0;
        assign b_if[g].status    = RGGEN_OKAY;
        always @(posedge clk) cnt <= hit ? cnt + 8'd1 : 8'd0;
    end

    // lat counts cycles from the handshake cycle N to the first cycle with response valid.
    task automatic issue(input bit sel_b, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         output int lat, output logic [1:0] status, output logic [31:0] rdata);
        req_write = wr; req_address = addr; req_write_data = wd; req_strobe = st;
        if (sel_b) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        req_write = ~wr; req_address = 8'hFF; req_write_data = 32'h5A5A5A5A; req_strobe = 4'h0;
        lat = 1;
        while (!(sel_b ? b_rsp_valid : a_rsp_valid) && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        status = sel_b ? b_rsp_status : a_rsp_status;
        rdata  = sel_b ? b_rsp_read_data : a_rsp_read_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        total++; if (a_rsp_status !== 2'b00) begin bad++; $display("FAIL reset_rsp_status got=%b exp=00", a_rsp_status); end
        total++; if (a_rsp_read_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", a_rsp_read_data); end
        total++; if (a_if[0].valid !== 1'b0) begin bad++; $display("FAIL reset_reg_valid got=%b exp=0", a_if[0].valid); end
        total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL reset_b_req_ready got=%b exp=1", b_req_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready got=%b exp=1", a_req_ready); end
    endtask

    task automatic test_write();
        int c0, c1, lat;
        logic [1:0] s;
        logic [31:0] d;
        g_a[1].wait_n = 8'd0; g_a[1].rdata = 32'h11111111;
        c0 = g_a[0].done_count; c1 = g_a[1].done_count;
        issue(1'b0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, lat, s, d);
        total++; if (lat !== 2) begin bad++; $display("FAIL write_latency got=%0d exp=2", lat); end
        total++; if (s !== 2'b00) begin bad++; $display("FAIL write_status got=%b exp=00", s); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL write_rdata got=%h exp=0", d); end
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL write_req_ready_busy got=%b exp=0", a_req_ready); end
        total++; if (g_a[1].done_count !== c1 + 1) begin bad++; $display("FAIL write_reg1_hit got=%0d exp=%0d", g_a[1].done_count, c1 + 1); end
        total++; if (g_a[0].done_count !== c0) begin bad++; $display("FAIL write_reg0_idle got=%0d exp=%0d", g_a[0].done_count, c0); end
        total++; if (g_a[1].last_access !== 2'b11) begin bad++; $display("FAIL write_access got=%b exp=11", g_a[1].last_access); end
        total++; if (g_a[1].last_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL write_wdata got=%h exp=deadbeef", g_a[1].last_wdata); end
        total++; if (g_a[1].last_strobe !== 4'hF) begin bad++; $display("FAIL write_strobe got=%h exp=f", g_a[1].last_strobe); end
        @(posedge clk); #1;
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL write_rsp_drop got=%b exp=0", a_rsp_valid); end
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL write_idle got=%b exp=1", a_req_ready); end
    endtask

    task automatic test_read();
        int lat;
        logic [1:0] s;
        logic [31:0] d;
        g_a[0].wait_n = 8'd3; g_a[0].rdata = 32'h12345678;
        issue(1'b0, 1'b0, 8'h00, 32'hFFFFFFFF, 4'h3, lat, s, d);
        total++; if (lat !== 5) begin bad++; $display("FAIL read_wait_latency got=%0d exp=5", lat); end
        total++; if (s !== 2'b00) begin bad++; $display("FAIL read_wait_status got=%b exp=00", s); end
        total++; if (d !== 32'h12345678) begin bad++; $display("FAIL read_wait_data got=%h exp=12345678", d); end
        total++; if (g_a[0].last_access !== 2'b10) begin bad++; $display("FAIL read_access got=%b exp=10", g_a[0].last_access); end
        total++; if (g_a[0].last_strobe !== 4'hF) begin bad++; $display("FAIL read_strobe got=%h exp=f", g_a[0].last_strobe); end
        total++; if (g_a[0].last_wdata !== 32'h0) begin bad++; $display("FAIL read_wdata got=%h exp=0", g_a[0].last_wdata); end
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 8'h06, 32'h0, 4'h0, lat, s, d);
        total++; if (lat !== 2) begin bad++; $display("FAIL read_unaligned_latency got=%0d exp=2", lat); end
        total++; if (d !== 32'h11111111) begin bad++; $display("FAIL read_unaligned_data got=%h exp=11111111", d); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int lat;
        logic [1:0] s;
        logic [31:0] d;
        g_b[0].wait_n = 8'd255; g_b[0].rdata = 32'hA5A50F0F;
        issue(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, lat, s, d);
        total++; if (lat !== 5) begin bad++; $display("FAIL timeout_latency got=%0d exp=5", lat); end
        total++; if (s !== 2'b10) begin bad++; $display("FAIL timeout_status got=%b exp=10", s); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL timeout_data got=%h exp=0", d); end
        total++; if (b_if[0].valid !== 1'b0) begin bad++; $display("FAIL timeout_valid_drop got=%b exp=0", b_if[0].valid); end
        @(posedge clk); #1;
        g_b[0].wait_n = 8'd3;
        issue(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, lat, s, d);
        total++; if (lat !== 5) begin bad++; $display("FAIL ready_at_limit_latency got=%0d exp=5", lat); end
        total++; if (s !== 2'b00) begin bad++; $display("FAIL ready_at_limit_status got=%b exp=00", s); end
        total++; if (d !== 32'hA5A50F0F) begin bad++; $display("FAIL ready_at_limit_data got=%h exp=a5a50f0f", d); end
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        int lat;
        logic [1:0] s;
        logic [31:0] d;
        issue(1'b0, 1'b0, 8'h40, 32'h0, 4'h0, lat, s, d);
        total++; if (lat !== 2) begin bad++; $display("FAIL decode_err_latency got=%0d exp=2", lat); end
        total++; if (s !== 2'b10) begin bad++; $display("FAIL decode_err_status got=%b exp=10", s); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL decode_err_data got=%h exp=0", d); end
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 8'h40, 32'h0, 4'h0, lat, s, d);
        total++; if (lat !== 2) begin bad++; $display("FAIL decode_okay_latency got=%0d exp=2", lat); end
        total++; if (s !== 2'b00) begin bad++; $display("FAIL decode_okay_status got=%b exp=00", s); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL decode_okay_data got=%h exp=0", d); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [1:0] s;
        logic [31:0] d;
        rsp_ready = 1'b0;
        g_a[1].wait_n = 8'd0; g_a[1].rdata = 32'hCAFEF00D; g_a[1].st = 2'b10;
        issue(1'b0, 1'b0, 8'h04, 32'h0, 4'h0, lat, s, d);
        total++; if (lat !== 2) begin bad++; $display("FAIL hold_latency got=%0d exp=2", lat); end
        total++; if (s !== 2'b10) begin bad++; $display("FAIL hold_merged_status got=%b exp=10", s); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (a_rsp_valid !== 1'b1 || a_rsp_status !== 2'b10 || a_rsp_read_data !== 32'hCAFEF00D || a_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable cycle=%0d got=%b/%b/%h/%b exp=1/10/cafef00d/0",
                         i, a_rsp_valid, a_rsp_status, a_rsp_read_data, a_req_ready);
            end
        end
        rsp_ready = 1'b1;
        g_a[1].st = 2'b00;
        @(posedge clk); #1;
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL hold_accept got=%b exp=0", a_rsp_valid); end
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_after got=%b exp=1", a_req_ready); end
        g_a[0].wait_n = 8'd0; g_a[0].rdata = 32'h00000000;
        issue(1'b0, 1'b1, 8'h00, 32'h01020304, 4'h5, lat, s, d);
        total++; if (lat !== 2 || s !== 2'b00) begin bad++; $display("FAIL b2b_write got=%0d/%b exp=2/00", lat, s); end
        total++; if (g_a[0].last_strobe !== 4'h5) begin bad++; $display("FAIL b2b_strobe got=%h exp=5", g_a[0].last_strobe); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [1:0] s;
        logic [31:0] d;
        g_a[0].wait_n = 8'd255;
        req_write = 1'b0; req_address = 8'h00; a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        total++; if (a_if[0].valid !== 1'b1) begin bad++; $display("FAIL mid_valid_up got=%b exp=1", a_if[0].valid); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        total++; if (a_if[0].valid !== 1'b0) begin bad++; $display("FAIL mid_valid_async_drop got=%b exp=0", a_if[0].valid); end
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL mid_req_ready got=%b exp=1", a_req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
                bad++;
                $display("FAIL mid_no_response cycle=%0d got=%b/%b exp=0/1", i, a_rsp_valid, a_req_ready);
            end
        end
        g_a[0].wait_n = 8'd0; g_a[0].rdata = 32'h0BADF00D;
        issue(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, lat, s, d);
        total++; if (lat !== 2 || s !== 2'b00) begin bad++; $display("FAIL mid_next_txn got=%0d/%b exp=2/00", lat, s); end
        total++; if (d !== 32'h0BADF00D) begin bad++; $display("FAIL mid_next_data got=%h exp=0badf00d", d); end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_decode();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rggen_native_bus_bridge.md
Name: rggen_native_bus_bridge

Overview:
Upstream stage of the register array. It converts a simple valid/ready request/response host bus into `rggen_register_if` transactions, fanned out to REGISTERS register instances. It merges their responses and generates decode-error and timeout responses itself. It holds one outstanding transaction, and the response is held until the host accepts it.

Parameters:
- ADDRESS_WIDTH, 8: host/register address width, byte addressed.
- BUS_WIDTH, 32: data width; a multiple of 8.
- REGISTERS, 1: number of attached `rggen_register_if` instances; ≥1.
- ERROR_STATUS, 1: 1 = unmapped access returns RGGEN_SLAVE_ERROR; 0 = returns RGGEN_OKAY with zero read data.
- TIMEOUT_CYCLES, 0: wait-cycle limit after a register goes active; 0 disables the timeout.
- COUNTER_WIDTH, 8: timeout counter width; requires TIMEOUT_CYCLES < 2**COUNTER_WIDTH.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid && ready
- i_req_write  in  1  1 = write, 0 = read
- i_req_address  in  ADDRESS_WIDTH  byte address
- i_req_write_data  in  BUS_WIDTH  write data
- i_req_strobe  in  BUS_WIDTH/8  byte enables
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  host accepts response
- o_rsp_status  out  2  rggen_status encoding
- o_rsp_read_data  out  BUS_WIDTH  read data
- register_if  modport-array  REGISTERS  `rggen_register_if.host` [REGISTERS]

Behaviour:
- Clock is i_clk. Reset is i_rst_n: asynchronous, active-low.
- FSM states are IDLE, ACCESS and RESPOND. Reset state is IDLE.
- Reset values:
  - o_req_ready = 1 (equal to state==IDLE).
  - o_rsp_valid = 0, o_rsp_status = RGGEN_OKAY, o_rsp_read_data = 0.
  - register_if[*].valid = 0, and all captured request registers = 0.
- IDLE:
  - A handshake captures write, address (low $clog2(BUS_WIDTH/8) bits forced to 0), write data and strobe, then moves to ACCESS.
  - For reads: write data is captured as 0 and strobe as all-ones.
- ACCESS (register_if outputs):
  - register_if[*].valid = 1.
  - access = RGGEN_WRITE or RGGEN_READ.
  - address, write_data and strobe are broadcast from the captured registers.
  - The timeout counter is cleared on entry.
- ACCESS, evaluated each cycle in priority order:
  1. Any (active && ready): read_data and status are OR-reduced across registers, captured into response registers, then go to RESPOND.
  2. No register active: decode error. Status is SLAVE_ERROR if ERROR_STATUS=1, else OKAY. Read data is 0. Go to RESPOND. This is resolved in the first ACCESS cycle.
  3. Active && !ready: the counter increments. If TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES-1, respond SLAVE_ERROR with read data 0 and go to RESPOND.
- Ready and timeout in the same cycle: ready wins.
- Leaving ACCESS: register_if valid deasserts in the cycle after the completing cycle.
- RESPOND:
  - o_rsp_valid = 1 with payload stable.
  - On i_rsp_ready, go to IDLE. The next request can be accepted the cycle after.
- Write response read_data is 0.
- Latency: handshake at cycle N, ACCESS at N+1, o_rsp_valid at N+2 at minimum. Throughput is at most 1 transaction per 3 cycles.
- Reset mid-transaction: abort immediately to IDLE, no response is issued, and register_if valid drops asynchronously.
- Multiple active registers is illegal. OR-reduction is the defined result. Under RGGEN_ENABLE_SVA, assert $onehot0 of the active vector.
- Host-bus inputs are don't-care outside the IDLE handshake.
- SVA: o_rsp_valid && !i_rsp_ready |=> $stable(response payload).

Decomposition:
- rggen_access, rggen_status and their encodings come from rggen_rtl_pkg.
- Add a state enum `rggen_bridge_state` to rggen_rtl_pkg so other bus bridges can reuse it.
- Response merge uses the rggen_or_reducer sub-module (width BUS_WIDTH+2, N=REGISTERS).
- FSM, capture registers and counter stay in this module.

Test Plan (ADDRESS_WIDTH=8, BUS_WIDTH=32, REGISTERS=2):
1. Write 0xDEADBEEF, strobe 0xF, to 0x04 (reg1, ready on first ACCESS cycle) → reg1 sees write, o_rsp_valid at N+2, status OKAY, read data 0.
2. Read 0x00 with reg0 returning 0x12345678 after 3 wait cycles, TIMEOUT_CYCLES=8 → o_rsp_valid at N+5, read data 0x12345678, OKAY.
3. Read 0x40 (unmapped), ERROR_STATUS=1 → SLAVE_ERROR, data 0 at N+2. With ERROR_STATUS=0 → OKAY, data 0.
4. TIMEOUT_CYCLES=4, reg0 never ready → SLAVE_ERROR at N+5. Ready asserted on the 4th wait cycle → OKAY with data.
5. Hold i_rsp_ready=0 for 5 cycles → payload stable, o_req_ready=0 throughout; accepted next cycle after i_rsp_ready.
6. Assert i_rst_n=0 during ACCESS → valid drops immediately, no response, o_req_ready=1 after release, next transaction correct.
